// File: rtl/camera_sensor_sim.sv
// camera_sensor_sim: MT9V034-style parallel sensor emulator (LINE_VALID,
// FRAME_VALID, 10-bit DATA_OUT) with programmable active area and blanking.
// Ports:
//   PIXCLK      in   pixel clock, rising edge
//   RST_N       in   asynchronous active-low reset
//   ENABLE      in   frames are generated while high
//   MODE[1:0]   in   pattern: 0 GRID, 1 RAMP, 2 LFSR, 3 FRAMENUM
//   LINE_VALID  out  high during active pixels
//   FRAME_VALID out  high from first pixel to end of last line's HBLANK
//   DATA_OUT    out  pixel value, 0 while LINE_VALID is low
//   FRAME_COUNT out  completed frames, wraps
//   BUSY        out  high from frame start through end of VBLANK
// Build option: define CAMSIM_LFSR_EN to enable the MODE=2 LFSR pattern;
// without it MODE=2 produces the GRID pattern.
module camera_sensor_sim #(
    parameter int WIDTH  = 2,
    parameter int HEIGHT = 3,
    parameter int HBLANK = 1,
    parameter int VBLANK = 4
) (
    input  logic        PIXCLK,
    input  logic        RST_N,
    input  logic        ENABLE,
    input  logic [1:0]  MODE,
    output logic        LINE_VALID,
    output logic        FRAME_VALID,
    output logic [9:0]  DATA_OUT,
    output logic [15:0] FRAME_COUNT,
    output logic        BUSY
);

    localparam int CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int LW   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int BMAX = (HBLANK > VBLANK) ? HBLANK : VBLANK;
    localparam int BW   = (BMAX > 1) ? $clog2(BMAX) : 1;

    localparam logic [CW-1:0] COL_LAST  = CW'(WIDTH - 1);
    localparam logic [LW-1:0] LINE_LAST = LW'(HEIGHT - 1);
    localparam logic [BW-1:0] H_LAST    = BW'(HBLANK - 1);
    localparam logic [BW-1:0] V_LAST    = BW'(VBLANK - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        HBL,
        VBL
    } state_t;

    state_t        state;
    logic [CW-1:0] col;
    logic [LW-1:0] line;
    logic [BW-1:0] blank;
    logic [1:0]    mode_q;
    logic [9:0]    ramp;
`ifdef CAMSIM_LFSR_EN
    logic [9:0]    lfsr;
    logic [9:0]    lfsr_n;
`endif

    // Coordinates and pattern state of the pixel emitted on the next edge,
    // whichever of start-of-frame / next-column / next-line that turns out
    // to be.  Only consumed on edges that actually emit a pixel.
    logic          start_now;
    logic          first;
    logic [1:0]    p_mode;
    logic [LW-1:0] p_line;
    logic [CW-1:0] p_col;
    logic [9:0]    ramp_n;
    logic [9:0]    grid;
    logic [9:0]    px;

    always_comb begin
        start_now = 1'b0;
        first     = 1'b0;
        p_mode    = mode_q;
        p_line    = line;
        p_col     = col + CW'(1);
        if (state == IDLE || state == VBL) begin
            // MODE is latched at frame start, so the first pixel uses it live
            first  = 1'b1;
            p_mode = MODE;
            p_line = '0;
            p_col  = '0;
            if (ENABLE && (state == IDLE || blank == V_LAST)) begin
                start_now = 1'b1;
            end
        end else if (state == HBL) begin
            p_line = line + LW'(1);
            p_col  = '0;
        end

        ramp_n = first ? 10'd0 : ramp + 10'd1;
`ifdef CAMSIM_LFSR_EN
        lfsr_n = first ? 10'h001 : {lfsr[8:0], lfsr[9] ^ lfsr[6]};
`endif
        grid = (10'(p_line) + 10'd1) * 10'd10 + 10'(p_col) + 10'd1;

        case (p_mode)
            2'd1:    px = ramp_n;
`ifdef CAMSIM_LFSR_EN
            2'd2:    px = lfsr_n;
`endif
            2'd3:    px = FRAME_COUNT[9:0];
            default: px = grid;
        endcase
    end

    always_ff @(posedge PIXCLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= IDLE;
            col         <= '0;
            line        <= '0;
            blank       <= '0;
            mode_q      <= 2'd0;
            ramp        <= 10'd0;
`ifdef CAMSIM_LFSR_EN
            lfsr        <= 10'd0;
`endif
            LINE_VALID  <= 1'b0;
            FRAME_VALID <= 1'b0;
            DATA_OUT    <= 10'd0;
            FRAME_COUNT <= 16'd0;
            BUSY        <= 1'b0;
        end else if (start_now) begin
            state       <= ACTIVE;
            col         <= '0;
            line        <= '0;
            blank       <= '0;
            mode_q      <= MODE;
            ramp        <= ramp_n;
`ifdef CAMSIM_LFSR_EN
            lfsr        <= lfsr_n;
`endif
            LINE_VALID  <= 1'b1;
            FRAME_VALID <= 1'b1;
            DATA_OUT    <= px;
            BUSY        <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    BUSY <= 1'b0;
                end
                ACTIVE: begin
                    if (col == COL_LAST) begin
                        state      <= HBL;
                        blank      <= '0;
                        LINE_VALID <= 1'b0;
                        DATA_OUT   <= 10'd0;
                    end else begin
                        col      <= p_col;
                        ramp     <= ramp_n;
`ifdef CAMSIM_LFSR_EN
                        lfsr     <= lfsr_n;
`endif
                        DATA_OUT <= px;
                    end
                end
                HBL: begin
                    if (blank != H_LAST) begin
                        blank <= blank + BW'(1);
                    end else if (line != LINE_LAST) begin
                        state      <= ACTIVE;
                        line       <= p_line;
                        col        <= '0;
                        ramp       <= ramp_n;
`ifdef CAMSIM_LFSR_EN
                        lfsr       <= lfsr_n;
`endif
                        LINE_VALID <= 1'b1;
                        DATA_OUT   <= px;
                    end else begin
                        // frame is complete once the last HBLANK ends
                        state       <= VBL;
                        blank       <= '0;
                        FRAME_VALID <= 1'b0;
                        FRAME_COUNT <= FRAME_COUNT + 16'd1;
                    end
                end
                VBL: begin
                    if (blank != V_LAST) begin
                        blank <= blank + BW'(1);
                    end else begin
                        // ENABLE high here was taken by start_now
                        state <= IDLE;
                        blank <= '0;
                        BUSY  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_camera_sensor_sim.sv
// tb_camera_sensor_sim: scoreboard bench for camera_sensor_sim
// (default geometry 2x3, HBLANK 1, VBLANK 4).
module tb_camera_sensor_sim;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [1:0]  mode;
    logic        line_valid;
    logic        frame_valid;
    logic [9:0]  data_out;
    logic [15:0] frame_count;
    logic        busy;

    int errors = 0;
    int checks = 0;
    logic [9:0] sb[$];

    camera_sensor_sim dut (
        .PIXCLK      (clk),
        .RST_N       (rst_n),
        .ENABLE      (enable),
        .MODE        (mode),
        .LINE_VALID  (line_valid),
        .FRAME_VALID (frame_valid),
        .DATA_OUT    (data_out),
        .FRAME_COUNT (frame_count),
        .BUSY        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Expected pixels of one 2x3 frame for a given mode and frame number.
    task automatic push_frame(input logic [1:0] m, input logic [15:0] fc);
        logic [9:0] r;
        logic [9:0] s;
        logic [9:0] v;
        r = 10'd0;
        s = 10'h001;
        for (int ln = 0; ln < 3; ln++) begin
            for (int c = 0; c < 2; c++) begin
                v = 10'((ln + 1) * 10 + c + 1);
                if (m == 2'd1) v = r;
`ifdef CAMSIM_LFSR_EN
                if (m == 2'd2) v = s;
`endif
                if (m == 2'd3) v = fc[9:0];
                sb.push_back(v);
                r = r + 10'd1;
                s = {s[8:0], s[9] ^ s[6]};
            end
        end
    endtask

    function automatic logic sig(input int which);
        case (which)
            0:       return frame_valid;
            1:       return line_valid;
            default: return busy;
        endcase
    endfunction

    // Counts negedges until the selected output equals v (bounded).
    task automatic wait_on(input int which, input logic v, input string tag,
                           output int n);
        n = 0;
        while (sig(which) !== v && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sig(which) !== v) chk(tag, 32'(sig(which)), 32'(v));
    endtask

    // Scoreboard consumer: every LINE_VALID-high sample pops one pixel.
    always @(negedge clk) begin
        if (rst_n) begin
            if (line_valid) begin
                chk("sb_avail", 32'(sb.size() > 0), 1);
                if (sb.size() > 0) chk("pix", 32'(data_out), 32'(sb.pop_front()));
            end else begin
                chk("data_idle", 32'(data_out), 0);
            end
        end
    end

    initial begin
        int n;
        int fv_seen;
        rst_n  = 1'b0;
        enable = 1'b0;
        mode   = 2'd0;
        repeat (2) @(negedge clk);
        chk("rst_lv", 32'(line_valid), 0);
        chk("rst_fv", 32'(frame_valid), 0);
        chk("rst_data", 32'(data_out), 0);
        chk("rst_fc", 32'(frame_count), 0);
        chk("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;

        // frame 1: GRID, continuous enable
        @(negedge clk);
        enable = 1'b1;
        push_frame(2'd0, 16'd0);
        wait_on(0, 1'b1, "to_fv1", n);
        chk("latency", n, 1);
        chk("busy_on", 32'(busy), 1);
        wait_on(0, 1'b0, "to_fv1_fall", n);
        chk("fv_len1", n, 9);
        chk("fc1", 32'(frame_count), 1);
        chk("busy_vbl", 32'(busy), 1);
        push_frame(2'd0, 16'd1);
        wait_on(1, 1'b1, "to_lv2", n);
        chk("vbl_gap", n, 4);
        wait_on(0, 1'b0, "to_fv2_fall", n);
        chk("fv_len2", n, 9);
        chk("fc2", 32'(frame_count), 2);

        // frame 3: drop ENABLE during line 1, frame must still complete
        push_frame(2'd0, 16'd2);
        wait_on(0, 1'b1, "to_fv3", n);
        chk("period_gap", n, 4);
        repeat (3) @(negedge clk);
        enable = 1'b0;
        wait_on(0, 1'b0, "to_fv3_fall", n);
        chk("fc3", 32'(frame_count), 3);
        wait_on(2, 1'b0, "to_busy3", n);
        chk("busy_tail", n, 4);
        fv_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (frame_valid) fv_seen++;
        end
        chk("no_frame", fv_seen, 0);
        chk("fc3_hold", 32'(frame_count), 3);
        chk("sb_drain3", sb.size(), 0);

        // RAMP, with MODE changed mid-frame, then GRID, FRAMENUM, LFSR
        mode   = 2'd1;
        enable = 1'b1;
        push_frame(2'd1, 16'd3);
        wait_on(0, 1'b1, "to_fv4", n);
        repeat (2) @(negedge clk);
        mode = 2'd0;
        wait_on(0, 1'b0, "to_fv4_fall", n);
        chk("fc4", 32'(frame_count), 4);
        push_frame(2'd0, 16'd4);
        wait_on(0, 1'b1, "to_fv5", n);
        wait_on(0, 1'b0, "to_fv5_fall", n);
        chk("fc5", 32'(frame_count), 5);
        mode = 2'd3;
        push_frame(2'd3, 16'd5);
        wait_on(0, 1'b1, "to_fv6", n);
        wait_on(0, 1'b0, "to_fv6_fall", n);
        chk("fc6", 32'(frame_count), 6);
        mode = 2'd2;
        push_frame(2'd2, 16'd6);
        wait_on(0, 1'b1, "to_fv7", n);
        enable = 1'b0;
        wait_on(0, 1'b0, "to_fv7_fall", n);
        chk("fc7", 32'(frame_count), 7);
        wait_on(2, 1'b0, "to_busy7", n);
        chk("sb_drain7", sb.size(), 0);

        // asynchronous reset during pixel 21
        @(negedge clk);
        mode   = 2'd0;
        enable = 1'b1;
        push_frame(2'd0, 16'd7);
        wait_on(0, 1'b1, "to_fv8", n);
        repeat (3) @(negedge clk);
        chk("pre_rst", 32'(data_out), 21);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_lv", 32'(line_valid), 0);
        chk("arst_fv", 32'(frame_valid), 0);
        chk("arst_data", 32'(data_out), 0);
        chk("arst_fc", 32'(frame_count), 0);
        chk("arst_busy", 32'(busy), 0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        push_frame(2'd0, 16'd0);
        wait_on(0, 1'b1, "to_fv9", n);
        chk("rst_latency", n, 1);
        enable = 1'b0;
        wait_on(0, 1'b0, "to_fv9_fall", n);
        chk("fc_after_rst", 32'(frame_count), 1);
        wait_on(2, 1'b0, "to_busy9", n);
        chk("sb_drain9", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
